// File: rtl/symbol_freq_counter.sv
// Per-block histogram of 4-bit symbols feeding the Huffman sorter; the 16 counts are
// held stable on freq_bus until downstream acknowledges, then cleared for the next block.
module symbol_freq_counter #(
    parameter int CSIZE = 5,
    parameter int SSIZE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SSIZE-1:0]              sym,
    input  logic                          sym_valid,
    input  logic                          sym_last,
    output logic                          sym_ready,
    output logic [(2**SSIZE)*CSIZE-1:0]   freq_bus,
    output logic [SSIZE:0]                nz_cnt,
    output logic                          sat,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int NSYM = 2**SSIZE;
    localparam int NGRP = NSYM / 4;
    localparam logic [CSIZE-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t           state;
    logic [CSIZE-1:0] cnt [NSYM];
    logic             accept;
    logic [2:0]       grp;

    assign accept = sym_valid & sym_ready;

    function automatic logic [CSIZE-1:0] sat_inc(input logic [CSIZE-1:0] v);
        return (v == CMAX) ? v : v + CSIZE'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sym_ready <= 1'b0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
            for (int k = 0; k < NSYM; k++) cnt[k] <= '0;
        end else begin
            case (state)
                IDLE, COUNT: begin
                    sym_ready <= 1'b1;
                    if (accept) begin
                        for (int k = 0; k < NSYM; k++)
                            if (sym == SSIZE'(k)) cnt[k] <= sat_inc(cnt[k]);
                        if (cnt[sym] == CMAX) sat <= 1'b1;
                        if (sym_last) begin
                            state     <= HOLD;
                            sym_ready <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                HOLD: begin
                    // The acknowledge cycle doubles as the handoff cycle (sym_ready low).
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        sym_ready <= 1'b1;
                        sat       <= 1'b0;
                        for (int k = 0; k < NSYM; k++) cnt[k] <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sym_ready <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        freq_bus = '0;
        for (int k = 0; k < NSYM; k++) freq_bus[k*CSIZE +: CSIZE] = cnt[k];
    end

    // Two-level popcount: 4-input group sums, then a short chain over the groups.
    always_comb begin
        nz_cnt = '0;
        grp    = '0;
        for (int g = 0; g < NGRP; g++) begin
            grp = 3'(|cnt[4*g]) + 3'(|cnt[4*g+1]) + 3'(|cnt[4*g+2]) + 3'(|cnt[4*g+3]);
            nz_cnt = nz_cnt + (SSIZE+1)'(grp);
        end
    end

endmodule

// File: tb/tb_symbol_freq_counter.sv
// Randomized bench for symbol_freq_counter against a per-block count-array model.
module tb_symbol_freq_counter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sym;
    logic        sym_valid;
    logic        sym_last;
    logic        sym_ready;
    logic [79:0] freq_bus;
    logic [4:0]  nz_cnt;
    logic        sat;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    int mcnt [16];
    bit msat;

    symbol_freq_counter #(.CSIZE(5), .SSIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .sym(sym), .sym_valid(sym_valid), .sym_last(sym_last),
        .sym_ready(sym_ready), .freq_bus(freq_bus), .nz_cnt(nz_cnt), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [79:0] exp_bus();
        logic [79:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) b[k*5 +: 5] = 5'(mcnt[k]);
        return b;
    endfunction

    function automatic logic [4:0] exp_nz();
        int n;
        n = 0;
        for (int k = 0; k < 16; k++) if (mcnt[k] != 0) n++;
        return 5'(n);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 16; k++) mcnt[k] = 0;
        msat = 1'b0;
    endtask

    task automatic model_add(input int s);
        if (mcnt[s] >= 31) msat = 1'b1;
        else mcnt[s] = mcnt[s] + 1;
    endtask

    task automatic send(input logic [3:0] s, input bit last);
        int t;
        t = 0;
        @(negedge clk);
        sym = s; sym_valid = 1'b1; sym_last = last;
        while (sym_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL send_timeout: sym_ready=%b required 1", sym_ready);
            sym_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model_add(int'(s));
        sym_valid = 1'b0; sym_last = 1'b0; sym = 'x;
        checks++;
        if (freq_bus !== exp_bus()) begin
            errors++;
            $display("FAIL accept_freq: got %h required %h", freq_bus, exp_bus());
        end
        checks++;
        if (out_valid !== last) begin
            errors++;
            $display("FAIL accept_out_valid: got %b required %b", out_valid, last);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_block();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (sym_ready !== 1'b0 || out_valid !== 1'b0 || freq_bus !== '0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b ov=%b freq=%h sat=%b required 0/0/0/0", sym_ready, out_valid, freq_bus, sat);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", sym_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b required 1", sym_ready);
        end
        send(4'd1, 1'b0); send(4'd1, 1'b0); send(4'd6, 1'b0);
        @(negedge clk); rst_n = 1'b0; #1;
        model_clear();
        checks++;
        if (freq_bus !== '0 || out_valid !== 1'b0 || sym_ready !== 1'b0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid_count: freq=%h ov=%b ready=%b sat=%b required 0", freq_bus, out_valid, sym_ready, sat);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sym_ready !== 1'b1 || freq_bus !== '0) begin
            errors++;
            $display("FAIL ready_after_second_release: ready=%b freq=%h required 1/0", sym_ready, freq_bus);
        end
    endtask

    task automatic test_basic_block();
        logic [79:0] req;
        send(4'd3, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b0); send(4'd15, 1'b0); send(4'd0, 1'b1);
        req = '0;
        req[3*5 +: 5] = 5'd1; req[9*5 +: 5] = 5'd2; req[15*5 +: 5] = 5'd1; req[0 +: 5] = 5'd1;
        checks++;
        if (freq_bus !== req) begin
            errors++;
            $display("FAIL basic_freq: got %h required %h", freq_bus, req);
        end
        checks++;
        if (nz_cnt !== 5'd4 || sat !== 1'b0 || sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: nz=%0d sat=%b ready=%b required 4/0/0", nz_cnt, sat, sym_ready);
        end
        release_block();
        checks++;
        if (out_valid !== 1'b0 || freq_bus !== '0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: ov=%b freq=%h ready=%b required 0/0/1", out_valid, freq_bus, sym_ready);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) send(4'($urandom_range(0, 15)), 1'b0);
        send(4'd2, 1'b1);
        @(negedge clk);
        sym = 4'd12; sym_valid = 1'b1; sym_last = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (sym_ready !== 1'b0 || out_valid !== 1'b1 || freq_bus !== exp_bus()) begin
                errors++;
                $display("FAIL backpressure_hold: ready=%b ov=%b freq=%h required 0/1/%h", sym_ready, out_valid, freq_bus, exp_bus());
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        model_clear();
        checks++;
        if (out_valid !== 1'b0 || freq_bus !== '0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: ov=%b freq=%h ready=%b required 0/0/1", out_valid, freq_bus, sym_ready);
        end
        @(posedge clk); #1;
        model_add(12);
        sym_valid = 1'b0; sym = 'x;
        checks++;
        if (freq_bus !== exp_bus()) begin
            errors++;
            $display("FAIL backpressure_next_accept: got %h required %h", freq_bus, exp_bus());
        end
        send(4'd12, 1'b1);
        checks++;
        if (nz_cnt !== 5'd1 || freq_bus[12*5 +: 5] !== 5'd2) begin
            errors++;
            $display("FAIL backpressure_block: nz=%0d f12=%0d required 1/2", nz_cnt, freq_bus[12*5 +: 5]);
        end
        release_block();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 39; i++) send(4'd7, 1'b0);
        send(4'd7, 1'b1);
        checks++;
        if (freq_bus[7*5 +: 5] !== 5'd31 || sat !== 1'b1 || nz_cnt !== 5'd1) begin
            errors++;
            $display("FAIL saturation: f7=%0d sat=%b nz=%0d required 31/1/1", freq_bus[7*5 +: 5], sat, nz_cnt);
        end
        release_block();
        checks++;
        if (sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_cleared: got %b required 0", sat);
        end
        send(4'd2, 1'b1);
        checks++;
        if (sat !== 1'b0 || freq_bus !== exp_bus()) begin
            errors++;
            $display("FAIL post_sat_block: sat=%b freq=%h required 0/%h", sat, freq_bus, exp_bus());
        end
        release_block();
    endtask

    task automatic test_single();
        send(4'd5, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || freq_bus[5*5 +: 5] !== 5'd1 || nz_cnt !== 5'd1 || freq_bus !== exp_bus()) begin
            errors++;
            $display("FAIL single_symbol: ov=%b freq=%h nz=%0d required 1/%h/1", out_valid, freq_bus, nz_cnt, exp_bus());
        end
        release_block();
    endtask

    task automatic test_all16();
        int order [16];
        int j, tmp;
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 3));
            send(4'(order[i]), i == 15);
        end
        checks++;
        if (nz_cnt !== 5'd16 || freq_bus !== {16{5'd1}}) begin
            errors++;
            $display("FAIL all16: nz=%0d freq=%h required 16/all ones", nz_cnt, freq_bus);
        end
        release_block();
    endtask

    task automatic test_random_blocks();
        int len;
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) begin
                out_ready = (i < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                if ($urandom_range(0, 3) == 0) idle(1);
                send((b % 2) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15)), i == len - 1);
            end
            checks++;
            if (freq_bus !== exp_bus() || nz_cnt !== exp_nz() || sat !== msat) begin
                errors++;
                $display("FAIL random_block%0d: freq=%h nz=%0d sat=%b required %h/%0d/%b", b, freq_bus, nz_cnt, sat, exp_bus(), exp_nz(), msat);
            end
            release_block();
            checks++;
            if (freq_bus !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_release%0d: freq=%h ov=%b required 0/0", b, freq_bus, out_valid);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sym = '0; sym_valid = 1'b0; sym_last = 1'b0; out_ready = 1'b0;
        model_clear();
        test_reset();
        test_basic_block();
        test_backpressure();
        test_saturation();
        test_single();
        test_all16();
        test_random_blocks();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
